pcs_scrambler_66b: RTL and testbench
====================================

// Module: pcs_scrambler_66b
// PURPOSE
// - Parametrised self-synchronising x^58+x^39+1 scrambler/descrambler for the 10GBASE-R PCS (IEEE 802.3 cl.49).
// - TX instance: between the 64b/66b encoder and the gearbox. RX instance: between block sync and the decoder.
// - Generalises the first-generation TX-only scrambler with:
//   - configurable datapath width;
//   - a TX/RX mode;
//   - valid-qualified state advance;
//   - sync-header pass-through, seed load and bypass;
//   - a registered output stage.
// PARAMETERS
// - DATA_W      64       payload bits per beat; legal values 32 and 64 (half-rate or full-rate block)
// - DESCRAMBLE  0        0 = scramble (TX); 1 = descramble (RX)
// - SEED        58'h3FF_FFFF_FFFF_FFFF  reset/load value of the 58-bit history register
// PORTS
// - clk          in   1       PCS clock
// - nreset       in   1       asynchronous, active-low reset
// - valid_i      in   1       beat on head_i/data_i is valid
// - head_i       in   2       sync header; meaningful only on the first beat of a block, else ignored
// - data_i       in   DATA_W  payload; bit 0 transmitted first
// - bypass_i     in   1       1 = payload passes unscrambled; history register holds
// - seed_ld_i    in   1       1 = load SEED into history this cycle (test/debug)
// - valid_o      out  1       registered copy of valid_i
// - head_o       out  2       registered copy of head_i, never scrambled
// - data_o       out  DATA_W  scrambled/descrambled payload
// BEHAVIOUR
// - Reset (nreset=0, async):
//   - history <= SEED;
//   - valid_o=0, head_o=2'b00, data_o='0.
// - Latency: exactly 1 cycle, input to output; no backpressure.
//   - The block is a pure valid-qualified pipeline stage.
// - Bit equation, per beat. x[k] for k<0 = history, with h[0] the most recent bit; x[-k-1] = h[k].
//   - x[j] = d[j] ^ x[j-39] ^ x[j-58], for j = 0..DATA_W-1.
//   - TX (DESCRAMBLE=0): x is the output, and its earlier bits feed back.
//   - RX (DESCRAMBLE=1): the taps use earlier *input* bits. out[j] = d[j] ^ in[j-39] ^ in[j-58], with in[k<0] = h.
// - History update when valid_i=1 and bypass_i=0:
//   - new h = last 58 bits of {h, shift-source}, where shift-source = scrambled output (TX) or raw input (RX);
//   - newest bit = bit DATA_W-1.
//   - DATA_W=32: history still 58 bits, spanning the previous beat.
// - valid_i=0: history holds; data_o/head_o hold their previous values; valid_o=0.
// - bypass_i=1 with valid_i=1: data_o=data_i, history holds.
// - seed_ld_i=1: history <= SEED. It wins over a concurrent valid beat.
//   - That beat is still output, processed with the pre-load history.
// - head_i is delayed alongside the data, unmodified. The block does not check header legality.
// - Reset mid-stream: outputs clear immediately; the first valid beat after release uses SEED.
//   - RX self-resynchronises after 58 valid input bits.
// STRUCTURE
// - Shared package pcs_pkg holds:
//   - SCR_W=58, SCR_TAP_A=39, SCR_TAP_B=58;
//   - HEAD_DATA=2'b01, HEAD_CTRL=2'b10;
//   - typedef scr_state_t = logic[57:0].
// - Sub-module pcs_scr_comb: purely combinational next-data/next-history function, parametrised by DATA_W and DESCRAMBLE.
//   - The top module holds the history flop, seed/bypass/valid muxing and the output register.
// TESTING
// - Zero in, zero state: SEED=0, TX, data=64'h0 for 4 beats -> data_o=0 every beat.
// - Seed response: SEED=all-ones, TX, one beat of data=64'h0 -> data_o=64'h03FF_FF80_0000_0000, 1 cycle after valid_i.
// - Loopback: TX (SEED all-ones) -> RX (SEED=0), 1000 random beats, random valid gaps.
//   - RX first beat: bits 58..63 match; all later beats match the TX input exactly.
//   - head_o matches at both ends.
// - Gaps/bypass: valid_i=0 for 5 cycles mid-stream, then bypass_i=1 for 2 beats.
//   - Both leave history unchanged.
//   - Compare the stream against a reference model with the gaps and bypassed beats deleted.
//   - Bypassed beats come out equal to their input.
// - Seed load and reset: seed_ld_i with valid_i=1 -> that beat uses the old history; the next beat matches a SEED-started model.
//   - nreset asserted mid-beat -> valid_o/data_o drop to 0 asynchronously.
//   - Restart matches a SEED-started model.
// - DATA_W=32: repeat the loopback test; the concatenated 32-bit outputs equal the 64-bit build bit-for-bit.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared constants and types for the 10GBASE-R PCS datapath.
// Scrambler polynomial x^58 + x^39 + 1 and 64b/66b sync headers.
package pcs_pkg;

   localparam int SCR_W     = 58;
   localparam int SCR_TAP_A = 39;
   localparam int SCR_TAP_B = 58;

   localparam logic [1:0] HEAD_DATA = 2'b01;
   localparam logic [1:0] HEAD_CTRL = 2'b10;

   typedef logic [SCR_W-1:0] scr_state_t;

endpackage

// File: rtl/pcs_scr_comb.sv
// Combinational x^58+x^39+1 block scrambler/descrambler step.
// hist[0] is the most recently shifted bit; data bit 0 goes first.
module pcs_scr_comb
   import pcs_pkg::*;
#(
   parameter int DATA_W     = 64,
   parameter bit DESCRAMBLE = 1'b0
) (
   input  scr_state_t        hist,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] data_nxt,
   output scr_state_t        hist_nxt
);

   always_comb begin
      // ext[SCR_W+j] is stream bit j; ext[SCR_W-1-k] is hist[k]
      logic [SCR_W+DATA_W-1:0] ext;
      ext      = '0;
      data_nxt = '0;
      hist_nxt = '0;
      for (int k = 0; k < SCR_W; k++)
         ext[SCR_W-1-k] = hist[k];
      for (int j = 0; j < DATA_W; j++) begin
         data_nxt[j] = data[j]
                     ^ ext[j+SCR_W-SCR_TAP_A]
                     ^ ext[j+SCR_W-SCR_TAP_B];
         ext[j+SCR_W] = DESCRAMBLE ? data[j] : data_nxt[j];
      end
      for (int k = 0; k < SCR_W; k++)
         hist_nxt[k] = ext[SCR_W+DATA_W-1-k];
   end

endmodule

// File: rtl/pcs_scrambler_66b.sv
// Self-synchronising 64b/66b scrambler (TX) or descrambler (RX)
// with valid-qualified history, seed load, bypass and output register.
module pcs_scrambler_66b
   import pcs_pkg::*;
#(
   parameter int         DATA_W     = 64,
   parameter bit         DESCRAMBLE = 1'b0,
   parameter scr_state_t SEED       = 58'h3FF_FFFF_FFFF_FFFF
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              valid_i,
   input  logic [1:0]        head_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              bypass_i,
   input  logic              seed_ld_i,
   output logic              valid_o,
   output logic [1:0]        head_o,
   output logic [DATA_W-1:0] data_o
);

   scr_state_t        hist;
   scr_state_t        hist_nxt;
   logic [DATA_W-1:0] scr_data;

   pcs_scr_comb #(
      .DATA_W    (DATA_W),
      .DESCRAMBLE(DESCRAMBLE)
   ) u_comb (
      .hist    (hist),
      .data    (data_i),
      .data_nxt(scr_data),
      .hist_nxt(hist_nxt)
   );

   // seed load overrides the advance of a concurrent beat
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         hist <= SEED;
      end else if (seed_ld_i) begin
         hist <= SEED;
      end else if (valid_i && !bypass_i) begin
         hist <= hist_nxt;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_o <= 1'b0;
         head_o  <= 2'b00;
         data_o  <= '0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            head_o <= head_i;
            data_o <= bypass_i ? data_i : scr_data;
         end
      end
   end

endmodule

// File: tb/tb_pcs_scrambler_66b.sv
// Directed bench: TX/RX 64-bit loopback, zero-seed build and 32-bit build
// checked against a bit-serial scrambler model.
module tb_pcs_scrambler_66b;
   import pcs_pkg::*;

   localparam logic [57:0] SEED1 = 58'h3FF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;

   logic        v = 1'b0, byp = 1'b0, sld = 1'b0;
   logic [1:0]  h = 2'b00;
   logic [63:0] d = '0;
   logic        tx_v, tz_v, rx_v;
   logic [1:0]  tx_h, tz_h, rx_h;
   logic [63:0] tx_d, tz_d, rx_d;

   logic        v32 = 1'b0;
   logic [31:0] d32 = '0;
   logic        tx32_v, rx32_v;
   logic [1:0]  tx32_h, rx32_h;
   logic [31:0] tx32_d, rx32_d;

   int n_checks = 0;
   int n_errors = 0;

   logic [57:0] msr;
   logic [63:0] last_d;
   logic [1:0]  last_h;
   bit          rec = 0;
   bit          rx_en = 0;
   bit          rx32_en = 0;
   int          rx_n = 0;
   int          rx32_n = 0;

   logic [63:0] rec_in[$];
   logic [63:0] rec_out[$];
   logic [65:0] rx_q[$];
   logic [31:0] rx32_q[$];

   always #5 clk = ~clk;

   pcs_scrambler_66b #(.DATA_W(64), .DESCRAMBLE(1'b0), .SEED(SEED1)) u_tx (
      .clk(clk), .nreset(nreset), .valid_i(v), .head_i(h), .data_i(d),
      .bypass_i(byp), .seed_ld_i(sld),
      .valid_o(tx_v), .head_o(tx_h), .data_o(tx_d));

   pcs_scrambler_66b #(.DATA_W(64), .DESCRAMBLE(1'b0), .SEED(58'h0)) u_tz (
      .clk(clk), .nreset(nreset), .valid_i(v), .head_i(h), .data_i(d),
      .bypass_i(byp), .seed_ld_i(sld),
      .valid_o(tz_v), .head_o(tz_h), .data_o(tz_d));

   pcs_scrambler_66b #(.DATA_W(64), .DESCRAMBLE(1'b1), .SEED(58'h0)) u_rx (
      .clk(clk), .nreset(nreset), .valid_i(tx_v), .head_i(tx_h),
      .data_i(tx_d), .bypass_i(1'b0), .seed_ld_i(1'b0),
      .valid_o(rx_v), .head_o(rx_h), .data_o(rx_d));

   pcs_scrambler_66b #(.DATA_W(32), .DESCRAMBLE(1'b0), .SEED(SEED1)) u_tx32 (
      .clk(clk), .nreset(nreset), .valid_i(v32), .head_i(HEAD_DATA),
      .data_i(d32), .bypass_i(1'b0), .seed_ld_i(1'b0),
      .valid_o(tx32_v), .head_o(tx32_h), .data_o(tx32_d));

   pcs_scrambler_66b #(.DATA_W(32), .DESCRAMBLE(1'b1), .SEED(58'h0)) u_rx32 (
      .clk(clk), .nreset(nreset), .valid_i(tx32_v), .head_i(tx32_h),
      .data_i(tx32_d), .bypass_i(1'b0), .seed_ld_i(1'b0),
      .valid_o(rx32_v), .head_o(rx32_h), .data_o(rx32_d));

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // serial reference: msr[0] is the newest scrambled bit
   task automatic model(input logic [63:0] din, output logic [63:0] dout);
      logic s;
      dout = '0;
      for (int i = 0; i < 64; i++) begin
         s = din[i] ^ msr[38] ^ msr[57];
         dout[i] = s;
         msr = {msr[56:0], s};
      end
   endtask

   task automatic send64(input logic [1:0] hd, input logic [63:0] dd,
                         input logic bp, input logic sl);
      logic [63:0] e;
      v = 1'b1; h = hd; d = dd; byp = bp; sld = sl;
      @(posedge clk); #1;
      if (bp) e = dd;
      else model(dd, e);
      if (sl) msr = SEED1;
      check("tx_valid", 64'(tx_v), 64'd1);
      check("tx_head", 64'(tx_h), 64'(hd));
      check("tx_data", tx_d, e);
      last_d = e;
      last_h = hd;
      if (rx_en) rx_q.push_back({hd, dd});
      if (rec) begin
         rec_in.push_back(dd);
         rec_out.push_back(e);
      end
      v = 1'b0; byp = 1'b0; sld = 1'b0;
   endtask

   task automatic idle(input int n);
      v = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("gap_valid", 64'(tx_v), 64'd0);
         check("gap_data_hold", tx_d, last_d);
         check("gap_head_hold", 64'(tx_h), 64'(last_h));
      end
   endtask

   always @(negedge clk) begin
      if (rx_en && rx_v) begin
         if (rx_q.size() == 0) begin
            check("rx_unexpected_beat", 64'd1, 64'd0);
         end else begin
            logic [65:0] e;
            e = rx_q.pop_front();
            if (rx_n == 0)
               check("rx_first_bits", 64'(rx_d[63:58]), 64'(e[63:58]));
            else
               check("rx_data", rx_d, e[63:0]);
            check("rx_head", 64'(rx_h), 64'(e[65:64]));
            rx_n++;
         end
      end
   end

   always @(negedge clk) begin
      if (rx32_en && rx32_v) begin
         if (rx32_q.size() == 0) begin
            check("rx32_unexpected_beat", 64'd1, 64'd0);
         end else begin
            logic [31:0] e;
            e = rx32_q.pop_front();
            if (rx32_n == 1)
               check("rx32_first_bits", 64'(rx32_d[31:26]), 64'(e[31:26]));
            else if (rx32_n > 1)
               check("rx32_data", 64'(rx32_d), 64'(e));
            rx32_n++;
         end
      end
   end

   initial begin
      logic [63:0] r;
      logic [1:0]  hd;
      msr = SEED1;
      last_d = '0;
      last_h = 2'b00;

      #1;
      check("rst_valid", 64'(tx_v), 64'd0);
      check("rst_head", 64'(tx_h), 64'd0);
      check("rst_data", tx_d, 64'd0);
      repeat (2) @(posedge clk);
      #3 nreset = 1'b1;
      @(posedge clk); #1;

      // zero seed / seed response, then random loopback
      rec = 1;
      rx_en = 1;
      for (int i = 0; i < 4; i++) begin
         send64(HEAD_DATA, 64'h0, 1'b0, 1'b0);
         check("zero_state_data", tz_d, 64'h0);
         if (i == 0)
            check("seed_response", tx_d, 64'h03FF_FF80_0000_0000);
      end
      for (int i = 0; i < 1000; i++) begin
         r  = {$urandom, $urandom};
         hd = ($urandom_range(1) == 0) ? HEAD_DATA : HEAD_CTRL;
         send64(hd, r, 1'b0, 1'b0);
         if ($urandom_range(3) == 0) idle(1 + $urandom_range(2));
      end
      idle(3);
      rx_en = 0;
      rec = 0;
      check("rx_queue_drained", 64'(rx_q.size()), 64'd0);

      // gaps and bypass leave history alone
      for (int i = 0; i < 3; i++) send64(HEAD_DATA, {$urandom, $urandom}, 1'b0, 1'b0);
      idle(5);
      send64(HEAD_CTRL, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
      send64(HEAD_DATA, 64'hFFFF_0000_A5A5_5A5A, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) send64(HEAD_DATA, {$urandom, $urandom}, 1'b0, 1'b0);

      // seed load: beat uses old history, next beat restarts from SEED
      send64(HEAD_DATA, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1);
      send64(HEAD_DATA, 64'h0, 1'b0, 1'b0);
      check("seed_ld_restart", last_d, 64'h03FF_FF80_0000_0000);
      send64(HEAD_CTRL, {$urandom, $urandom}, 1'b0, 1'b0);

      // asynchronous reset in the middle of a beat
      v = 1'b1; h = HEAD_CTRL; d = 64'hCAFE_F00D_CAFE_F00D;
      #3 nreset = 1'b0;
      #1;
      check("async_rst_valid", 64'(tx_v), 64'd0);
      check("async_rst_data", tx_d, 64'd0);
      check("async_rst_head", 64'(tx_h), 64'd0);
      v = 1'b0;
      @(posedge clk);
      #3 nreset = 1'b1;
      @(posedge clk); #1;
      msr = SEED1;
      last_d = '0;
      last_h = 2'b00;
      send64(HEAD_DATA, 64'h0, 1'b0, 1'b0);
      check("post_rst_seed", tx_d, 64'h03FF_FF80_0000_0000);
      for (int i = 0; i < 4; i++) send64(HEAD_DATA, {$urandom, $urandom}, 1'b0, 1'b0);

      // 32-bit build replays the recorded 64-bit stream in halves
      rx32_en = 1;
      for (int i = 0; i < rec_in.size(); i++) begin
         for (int k = 0; k < 2; k++) begin
            v32 = 1'b1;
            d32 = (k == 0) ? rec_in[i][31:0] : rec_in[i][63:32];
            rx32_q.push_back(d32);
            @(posedge clk); #1;
            check("tx32_valid", 64'(tx32_v), 64'd1);
            if (k == 0) check("tx32_lo", 64'(tx32_d), 64'(rec_out[i][31:0]));
            else        check("tx32_hi", 64'(tx32_d), 64'(rec_out[i][63:32]));
            if ($urandom_range(5) == 0) begin
               v32 = 1'b0;
               @(posedge clk); #1;
               check("tx32_gap_valid", 64'(tx32_v), 64'd0);
            end
         end
      end
      v32 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rx32_en = 0;
      check("rx32_queue_drained", 64'(rx32_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
